// File: rtl/mpu_fault_pkg.sv
// Shared types and constants for the MPU fault unit; OP_LOAD/OP_STORE are also imported by the MPU.
package mpu_fault_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    LOCKED   = 2'd2
  } fault_state_t;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_t;

  // SYNDROME CSR layout, MSB first
  typedef struct packed {
    logic [7:0]  prio;
    logic [3:0]  id;
    logic [2:0]  rsvd;
    logic        is_store;
    logic [15:0] addr;
  } fault_syndrome_t;

  localparam csr_addr_t STATUS_OFS = 12'd0;
  localparam csr_addr_t SYND_OFS   = 12'd1;
  localparam csr_addr_t PC_OFS     = 12'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Ops that write the operand (set or replace); clear-type ops never trigger the STATUS clear.
  function automatic logic is_write_op(input csr_op_t o);
    return (o == CSRRW) || (o == CSRRS) || (o == CSRRWI) || (o == CSRRSI);
  endfunction

endpackage

// File: rtl/mpu_fault_csr.sv
// CSR decode for the fault unit: clear strobe and combinational read mux.
// With MPU_FAULT_PC_EN defined the PC CSR is mapped at CSR_BASE+2.
module mpu_fault_csr
  import mpu_fault_pkg::*;
#(
  parameter csr_addr_t CSR_BASE = 12'h440
) (
  input  logic        csr_enable,
  input  csr_addr_t   csr_addr,
  input  logic [31:0] rs1_data,
  input  csr_op_t     csr_op,
  input  logic [31:0] status_word,
  input  logic [31:0] synd_word,
`ifdef MPU_FAULT_PC_EN
  input  logic [31:0] pc_word,
`endif
  output logic        clear_req,
  output logic [31:0] csr_rdata
);

  logic sel_status;
  logic sel_synd;
  logic unused_rs1_hi;

  assign sel_status = (csr_addr == CSR_BASE + STATUS_OFS);
  assign sel_synd   = (csr_addr == CSR_BASE + SYND_OFS);

  // Only bit 0 of the operand is meaningful (the clear request).
  assign clear_req     = csr_enable && sel_status && rs1_data[0] && is_write_op(csr_op);
  assign unused_rs1_hi = ^rs1_data[31:1];

  always_comb begin
    csr_rdata = '0;
    if (sel_status) begin
      csr_rdata = status_word;
    end else if (sel_synd) begin
      csr_rdata = synd_word;
    end
`ifdef MPU_FAULT_PC_EN
    else if (csr_addr == CSR_BASE + PC_OFS) begin
      csr_rdata = pc_word;
    end
`endif
  end

endmodule

// File: rtl/mpu_fault_unit.sv
// MPU fault capture: first-fault syndrome, saturating follow-on counter, IRQ and double-fault halt.
// Optional MPU_FAULT_PC_EN adds a pc input and captures the faulting pc.
module mpu_fault_unit
  import mpu_fault_pkg::*;
#(
  parameter csr_addr_t  CSR_BASE   = 12'h440,
  parameter logic [7:0] FAULT_PRIO = 8'd7,
  parameter int         CNT_W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_fault,
  input  logic [15:0]  mem_address,
  input  logic [6:0]   op,
  input  logic [7:0]   interrupt_prio,
  input  logic [3:0]   id,
`ifdef MPU_FAULT_PC_EN
  input  logic [31:0]  pc,
`endif
  input  logic         csr_enable,
  input  csr_addr_t    csr_addr,
  input  logic [31:0]  rs1_data,
  input  csr_op_t      csr_op,
  output logic [31:0]  csr_rdata,
  output logic         fault_irq,
  output logic         halt_req,
  output fault_state_t dbg_state
);

  fault_state_t    state_q, state_d;
  fault_syndrome_t synd_q, synd_d, new_synd;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            ovf_q, ovf_d;
  logic            fault_ev, dbl_fault, clear_req, take_new, wipe;
  logic [31:0]     status_word;

  assign fault_ev  = mem_fault && ((op == OP_LOAD) || (op == OP_STORE));
  assign dbl_fault = fault_ev && (interrupt_prio == FAULT_PRIO);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  assign new_synd = '{prio: interrupt_prio, id: id, rsvd: 3'b000,
                      is_store: (op == OP_STORE), addr: mem_address};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      synd_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      synd_q  <= synd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    synd_d   = synd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    take_new = 1'b0;
    wipe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fault_ev) begin
          take_new = 1'b1;
          cnt_d    = CNT_W'(1);
          ovf_d    = 1'b0;
          state_d  = dbl_fault ? LOCKED : CAPTURED;
        end
      end
      CAPTURED: begin
        // A fault arriving together with a clear restarts capture from scratch.
        if (fault_ev && clear_req) begin
          take_new = 1'b1;
          cnt_d    = CNT_W'(1);
          ovf_d    = 1'b0;
          state_d  = dbl_fault ? LOCKED : CAPTURED;
        end else if (fault_ev) begin
          cnt_d = cnt_inc;
          ovf_d = 1'b1;
          if (dbl_fault) begin
            take_new = 1'b1;
            state_d  = LOCKED;
          end
        end else if (clear_req) begin
          wipe    = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (fault_ev) begin
          cnt_d = cnt_inc;
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_new) synd_d = new_synd;
    if (wipe)     synd_d = '0;
  end

  assign fault_irq   = (state_q != IDLE);
  assign halt_req    = (state_q == LOCKED);
  assign dbg_state   = state_q;
  assign status_word = {16'h0000, 8'(cnt_q), 5'b00000, halt_req, ovf_q, fault_irq};

`ifdef MPU_FAULT_PC_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset || wipe) pc_q <= '0;
    else if (take_new) pc_q <= pc;
  end
`endif

  mpu_fault_csr #(.CSR_BASE(CSR_BASE)) u_csr (
    .csr_enable  (csr_enable),
    .csr_addr    (csr_addr),
    .rs1_data    (rs1_data),
    .csr_op      (csr_op),
    .status_word (status_word),
    .synd_word   (synd_q),
`ifdef MPU_FAULT_PC_EN
    .pc_word     (pc_q),
`endif
    .clear_req   (clear_req),
    .csr_rdata   (csr_rdata)
  );

endmodule

// File: tb/tb_mpu_fault_unit.sv
// Self-checking bench for mpu_fault_unit; expected values queued at stimulus time, popped at observation.
module tb_mpu_fault_unit;
  import mpu_fault_pkg::*;

  localparam logic [11:0] A_STATUS = 12'h440;
  localparam logic [11:0] A_SYND   = 12'h441;
  localparam logic [11:0] A_PC     = 12'h442;
  localparam int S_IRQ = 0, S_HALT = 1, S_STATUS = 2, S_SYND = 3, S_PC = 4, S_STATE = 5;

  logic         clk;
  logic         reset;
  logic         mem_fault;
  logic [15:0]  mem_address;
  logic [6:0]   op;
  logic [7:0]   interrupt_prio;
  logic [3:0]   id;
  logic         csr_enable;
  logic [11:0]  csr_addr;
  logic [31:0]  rs1_data;
  csr_op_t      csr_op;
  logic [31:0]  csr_rdata;
  logic         fault_irq;
  logic         halt_req;
  fault_state_t dbg_state;
`ifdef MPU_FAULT_PC_EN
  logic [31:0]  pc;
`endif

  logic [31:0] exp_q[$];
  int          sel_q[$];
  int          n_vec;
  int          n_err;

  mpu_fault_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_fault      (mem_fault),
    .mem_address    (mem_address),
    .op             (op),
    .interrupt_prio (interrupt_prio),
    .id             (id),
`ifdef MPU_FAULT_PC_EN
    .pc             (pc),
`endif
    .csr_enable     (csr_enable),
    .csr_addr       (csr_addr),
    .rs1_data       (rs1_data),
    .csr_op         (csr_op),
    .csr_rdata      (csr_rdata),
    .fault_irq      (fault_irq),
    .halt_req       (halt_req),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected PC CSR value for a fault at address a (0 when the PC CSR is not built).
  function automatic logic [31:0] pc_of(input logic [15:0] a);
`ifdef MPU_FAULT_PC_EN
    return 32'h8000_0000 | {16'h0000, a};
`else
    return 32'h0000_0000 & {16'h0000, a};
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    csr_enable = 1'b1;
    csr_op     = CSRRS;
    rs1_data   = 32'h0;
    csr_addr   = a;
    #1;
    d          = csr_rdata;
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
    csr_addr   = 12'h000;
  endtask

  task automatic sample(input int sel, output logic [31:0] v);
    case (sel)
      S_IRQ:    v = {31'b0, fault_irq};
      S_HALT:   v = {31'b0, halt_req};
      S_STATUS: read_csr(A_STATUS, v);
      S_SYND:   read_csr(A_SYND, v);
      S_PC:     read_csr(A_PC, v);
      default:  v = {30'b0, dbg_state};
    endcase
  endtask

  task automatic drive_fault(input logic [15:0] a, input logic [6:0] o,
                             input logic [7:0] p, input logic [3:0] i);
    mem_fault      = 1'b1;
    mem_address    = a;
    op             = o;
    interrupt_prio = p;
    id             = i;
`ifdef MPU_FAULT_PC_EN
    pc             = 32'h8000_0000 | {16'h0000, a};
`endif
  endtask

  task automatic idle_inputs();
    mem_fault  = 1'b0;
    op         = 7'h00;
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
    rs1_data   = 32'h0;
    csr_addr   = 12'h000;
  endtask

  task automatic fault(input logic [15:0] a, input logic [6:0] o,
                       input logic [7:0] p, input logic [3:0] i);
    drive_fault(a, o, p, i);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic csr_write(input csr_op_t c, input logic [11:0] a, input logic [31:0] v);
    csr_enable = 1'b1;
    csr_op     = c;
    csr_addr   = a;
    rs1_data   = v;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic expect_val(input int sel, input logic [31:0] v);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got, exp;
    int sel;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_val(S_IRQ, 0); expect_val(S_HALT, 0); expect_val(S_STATUS, 0);
    expect_val(S_SYND, 0); expect_val(S_PC, 0); expect_val(S_STATE, 32'(IDLE));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL reset sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_first_load();
    logic [31:0] got, exp;
    int sel;
    fault(16'h0100, OP_LOAD, 8'd3, 4'd2);
    expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0101);
    expect_val(S_SYND, 32'h0320_0100); expect_val(S_PC, pc_of(16'h0100));
    expect_val(S_STATE, 32'(CAPTURED));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL first_load sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_follow_on();
    logic [31:0] got, exp;
    int sel;
    repeat (3) fault(16'h0200, OP_STORE, 8'd3, 4'd2);
    expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0403);
    expect_val(S_SYND, 32'h0320_0100); expect_val(S_PC, pc_of(16'h0100));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL follow_on sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] got, exp;
    int sel;
    csr_write(CSRRC, A_STATUS, 32'h1);
    csr_write(CSRRCI, A_STATUS, 32'h1);
    csr_write(CSRRW, A_STATUS, 32'hFFFF_FFFE);
    csr_write(CSRRW, A_SYND, 32'h1);
    csr_write(CSRRW, A_STATUS + 12'h10, 32'h1);
    expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0403);
    expect_val(S_SYND, 32'h0320_0100);
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL ignored_writes sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_clear(input csr_op_t c, input string name);
    logic [31:0] got, exp;
    int sel;
    csr_write(c, A_STATUS, 32'h1);
    expect_val(S_IRQ, 0); expect_val(S_STATUS, 0); expect_val(S_SYND, 0);
    expect_val(S_PC, 0); expect_val(S_STATE, 32'(IDLE));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL clear_%s sel=%0d got=%h exp=%h", name, sel, got, exp);
      end
    end
  endtask

  task automatic test_clear_with_event();
    logic [31:0] got, exp;
    int sel;
    fault(16'h0100, OP_LOAD, 8'd3, 4'd2);
    fault(16'h0180, OP_LOAD, 8'd3, 4'd2);
    drive_fault(16'h0300, OP_STORE, 8'd1, 4'd0);
    csr_enable = 1'b1; csr_op = CSRRW; csr_addr = A_STATUS; rs1_data = 32'h1;
    @(posedge clk); #1;
    idle_inputs();
    expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0101);
    expect_val(S_SYND, 32'h0101_0300); expect_val(S_PC, pc_of(16'h0300));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL clear_with_event sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_ignored_op();
    logic [31:0] got, exp;
    int sel;
    fault(16'h0400, 7'b0110011, 8'd3, 4'd1);
    fault(16'h0404, 7'b0110011, 8'd7, 4'd1);
    expect_val(S_IRQ, 0); expect_val(S_HALT, 0); expect_val(S_STATUS, 0);
    expect_val(S_SYND, 0);
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL ignored_op sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] got, exp;
    int sel;
    int n;
    n = $urandom_range(260, 300);
    repeat (n) fault(16'h0010, OP_LOAD, 8'd2, 4'd1);
    expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_FF03);
    expect_val(S_SYND, 32'h0210_0010);
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL saturate n=%0d sel=%0d got=%h exp=%h", n, sel, got, exp);
      end
    end
  endtask

  task automatic test_double_fault();
    logic [31:0] got, exp;
    int sel;
    fault(16'h0100, OP_LOAD, 8'd3, 4'd2);
    fault(16'h0ABC, OP_STORE, 8'd7, 4'd5);
    expect_val(S_HALT, 1); expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0207);
    expect_val(S_SYND, 32'h0751_0ABC); expect_val(S_PC, pc_of(16'h0ABC));
    expect_val(S_STATE, 32'(LOCKED));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL double_fault sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
    csr_write(CSRRW, A_STATUS, 32'h1);
    expect_val(S_HALT, 1); expect_val(S_IRQ, 1); expect_val(S_STATUS, 32'h0000_0207);
    expect_val(S_SYND, 32'h0751_0ABC); expect_val(S_STATE, 32'(LOCKED));
    while (exp_q.size() > 0) begin
      sel = sel_q.pop_front(); exp = exp_q.pop_front();
      sample(sel, got); n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL locked_clear sel=%0d got=%h exp=%h", sel, got, exp);
      end
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    mem_address    = 16'h0;
    interrupt_prio = 8'h0;
    id             = 4'h0;
`ifdef MPU_FAULT_PC_EN
    pc             = 32'h0;
`endif
    idle_inputs();
    test_reset();
    test_first_load();
    test_follow_on();
    test_ignored_writes();
    test_clear(CSRRW, "rw");
    test_clear_with_event();
    test_clear(CSRRSI, "rsi");
    test_ignored_op();
    test_saturate();
    test_clear(CSRRWI, "rwi");
    test_double_fault();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
